// File: rtl/warp_ibuf_pkg.sv
// Shared constants for the warp instruction buffer: default instruction width,
// stored entry width and decode-consume encodings.
package warp_pkg;
   localparam int INST_W  = 32;
   localparam int ENTRY_W = INST_W + 1;

   typedef enum logic [1:0] {
      DEQ_NONE = 2'd0,
      DEQ_ONE  = 2'd1,
      DEQ_TWO  = 2'd2
   } deq_e;
endpackage

// File: rtl/warp_ibuf_if.sv
// Fetch -> ibuf -> decode signal bundle. The master side is fetch/decode,
// and the slave side is the buffer itself.
interface warp_ibuf_if #(
   parameter int DEPTH  = 8,
   parameter int INST_W = warp_pkg::INST_W
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic              i_flush;
   logic              i_input_valid;
   logic              o_input_ready;
   logic [INST_W-1:0] i_inst0;
   logic [INST_W-1:0] i_inst1;
   logic [1:0]        i_compressed;
   logic              i_count;
   logic [INST_W-1:0] o_inst0;
   logic [INST_W-1:0] o_inst1;
   logic [1:0]        o_compressed;
   logic [1:0]        o_valid;
   logic [1:0]        i_deq_count;
   logic [OCC_W-1:0]  o_occupancy;

   modport master (
      output i_flush, i_input_valid, i_inst0, i_inst1, i_compressed, i_count, i_deq_count,
      input  o_input_ready, o_inst0, o_inst1, o_compressed, o_valid, o_occupancy
   );
   modport slave (
      input  i_flush, i_input_valid, i_inst0, i_inst1, i_compressed, i_count, i_deq_count,
      output o_input_ready, o_inst0, o_inst1, o_compressed, o_valid, o_occupancy
   );
endinterface

// File: rtl/warp_ibuf_ram.sv
// Entry storage: register array with two write ports and two asynchronous
// read ports. There is no reset, because contents are qualified by occupancy.
module warp_ibuf_ram #(
   parameter int DEPTH = 8,
   parameter int W     = warp_pkg::ENTRY_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] wa0,
   input  logic [W-1:0]  wd0,
   input  logic          we1,
   input  logic [AW-1:0] wa1,
   input  logic [W-1:0]  wd1,
   input  logic [AW-1:0] ra0,
   output logic [W-1:0]  rd0,
   input  logic [AW-1:0] ra1,
   output logic [W-1:0]  rd1
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];
endmodule

// File: rtl/warp_ibuf.sv
// Fetch-to-decode instruction queue, FWFT on the two oldest entries.
// Define WARP_IBUF_BYPASS_EN to forward fetch straight to decode when empty.
module warp_ibuf
   import warp_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int INST_W = warp_pkg::INST_W
) (
   input logic       i_clk,
   input logic       i_rst,
   warp_ibuf_if.slave bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int OCC_W = AW + 1;

   logic [AW-1:0]    head, tail;
   logic [OCC_W-1:0] occ;
   logic             byp, acc, we0, we1;
   logic [1:0]       nbund, skip, enq_n, deq_n, vld;
   logic [INST_W:0]  e0, e1, wd0, rd0, rd1, o0, o1;

   assign e0 = {bus.i_compressed[0], bus.i_inst0};
   assign e1 = {bus.i_compressed[1], bus.i_inst1};

   // Ready depends on registered occupancy only, so a freeing dequeue helps next cycle.
   assign bus.o_input_ready = (occ <= OCC_W'(DEPTH - 2));
   assign bus.o_occupancy   = occ;

   always_comb begin
      byp = 1'b0;
`ifdef WARP_IBUF_BYPASS_EN
      byp = (occ == '0) && bus.i_input_valid && !bus.i_flush;
`endif
      acc   = bus.i_input_valid && bus.o_input_ready && !bus.i_flush;
      nbund = {1'b0, bus.i_count} + 2'd1;
      // Bypassed instructions that decode takes this cycle are never stored.
      skip  = byp ? bus.i_deq_count : 2'd0;
      enq_n = acc ? (nbund - skip) : 2'd0;
      deq_n = byp ? 2'd0 : bus.i_deq_count;
      we0   = acc && (nbund > skip);
      we1   = acc && bus.i_count && (skip == 2'd0);
      wd0   = (skip == 2'd0) ? e0 : e1;
   end

   warp_ibuf_ram #(.DEPTH(DEPTH), .W(INST_W + 1), .AW(AW)) u_ram (
      .clk (i_clk),
      .we0 (we0),
      .wa0 (tail),
      .wd0 (wd0),
      .we1 (we1),
      .wa1 (tail + AW'(1)),
      .wd1 (e1),
      .ra0 (head),
      .rd0 (rd0),
      .ra1 (head + AW'(1)),
      .rd1 (rd1)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         head <= head + AW'(deq_n);
         tail <= tail + AW'(enq_n);
         occ  <= occ + OCC_W'(enq_n) - OCC_W'(deq_n);
      end
   end

   always_comb begin
      vld = {occ >= OCC_W'(2), occ >= OCC_W'(1)};
      o0  = rd0;
      o1  = rd1;
`ifdef WARP_IBUF_BYPASS_EN
      if (byp) begin
         vld = {bus.i_count, 1'b1};
         o0  = e0;
         o1  = e1;
      end
`endif
      bus.o_valid      = vld;
      bus.o_inst0      = vld[0] ? o0[INST_W-1:0] : '0;
      bus.o_inst1      = vld[1] ? o1[INST_W-1:0] : '0;
      bus.o_compressed = {vld[1] & o1[INST_W], vld[0] & o0[INST_W]};
   end

   // Decode may only take what is presented, and never three.
   deq_legal: assert property (@(posedge i_clk) disable iff (i_rst || bus.i_flush)
      (bus.i_deq_count <= DEQ_TWO) && (32'(bus.i_deq_count) <= $countones(bus.o_valid)));
endmodule

// File: tb/tb_warp_ibuf.sv
// Directed bench for warp_ibuf (DEPTH 8): table of per-cycle vectors plus
// hand sequences for reset-in-flight and the optional bypass path.
module tb_warp_ibuf;
   logic gclk = 1'b0;
   logic rst;
   always #5 gclk = ~gclk;

   warp_ibuf_if #(.DEPTH(8), .INST_W(32)) bus ();
   warp_ibuf #(.DEPTH(8), .INST_W(32)) dut (.i_clk(gclk), .i_rst(rst), .bus(bus.slave));

   typedef struct {
      bit          fl, v, c;
      logic [1:0]  cm;
      logic [31:0] a, b;
      logic [1:0]  dq;
      logic [3:0]  e_occ;
      bit          e_rdy;
      logic [1:0]  e_vld;
      logic [31:0] e_a, e_b;
      logic [1:0]  e_cm;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(bit fl, bit v, bit c, logic [1:0] cm, logic [31:0] a, logic [31:0] b,
                               logic [1:0] dq, logic [3:0] eo, bit er, logic [1:0] ev,
                               logic [31:0] ea, logic [31:0] eb, logic [1:0] ec);
      vec_t t;
      t.fl = fl; t.v = v; t.c = c; t.cm = cm; t.a = a; t.b = b; t.dq = dq;
      t.e_occ = eo; t.e_rdy = er; t.e_vld = ev; t.e_a = ea; t.e_b = eb; t.e_cm = ec;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit fl, input bit v, input bit c, input logic [1:0] cm,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] dq);
      bus.i_flush = fl; bus.i_input_valid = v; bus.i_count = c; bus.i_compressed = cm;
      bus.i_inst0 = a; bus.i_inst1 = b; bus.i_deq_count = dq;
   endtask

   task automatic idle();
      drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 2'd0);
   endtask

   // Apply the driven inputs at one edge, then idle so sampling sees registered state.
   task automatic step();
      @(posedge gclk);
      #1;
      idle();
      #1;
   endtask

   task automatic chk_all(input string p, input logic [3:0] eo, input bit er, input logic [1:0] ev,
                          input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] ec);
      chk({p, " occ"},   64'(bus.o_occupancy),   64'(eo));
      chk({p, " ready"}, 64'(bus.o_input_ready), 64'(er));
      chk({p, " valid"}, 64'(bus.o_valid),       64'(ev));
      chk({p, " inst0"}, 64'(bus.o_inst0),       64'(ea));
      chk({p, " inst1"}, 64'(bus.o_inst1),       64'(eb));
      chk({p, " comp"},  64'(bus.o_compressed),  64'(ec));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Fill with 0x13.. two per cycle; ready drops once occupancy exceeds 6.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0, 1, 1, 2'b00, 32'h13 + 2*k, 32'h14 + 2*k, 2'd0,
                          4'(2*k + 2), (k < 2) ? 1'b1 : (k == 2), 2'b11, 32'h13, 32'h14, 2'b00));
      tbl.push_back(mk(0, 1, 1, 2'b00, 32'hEE, 32'hEF, 2'd1, 4'd7, 0, 2'b11, 32'h14, 32'h15, 2'b00));
      tbl.push_back(mk(0, 1, 0, 2'b00, 32'hAA, 32'h0,  2'd0, 4'd7, 0, 2'b11, 32'h14, 32'h15, 2'b00));
      tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,  32'h0,  2'd1, 4'd6, 1, 2'b11, 32'h15, 32'h16, 2'b00));
      // Steady enq2/deq2 at DEPTH-2; pointers wrap several times.
      for (int j = 0; j < 20; j++)
         tbl.push_back(mk(0, 1, 1, 2'b00, 32'h1B + 2*j, 32'h1C + 2*j, 2'd2,
                          4'd6, 1, 2'b11, 32'h17 + 2*j, 32'h18 + 2*j, 2'b00));
      tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,  32'h0,  2'd1, 4'd5, 1, 2'b11, 32'h3E, 32'h3F, 2'b00));
      // Flush beats a concurrent enqueue and dequeue.
      tbl.push_back(mk(1, 1, 1, 2'b11, 32'h50, 32'h51, 2'd2, 4'd0, 1, 2'b00, 32'h0, 32'h0, 2'b00));
      // Mixed bundle sizes and per-slot compressed flags, odd head alignment.
      tbl.push_back(mk(0, 1, 0, 2'b01, 32'h100, 32'h0,   2'd0, 4'd1, 1, 2'b01, 32'h100, 32'h0,   2'b01));
      tbl.push_back(mk(0, 1, 1, 2'b10, 32'h200, 32'h201, 2'd0, 4'd3, 1, 2'b11, 32'h100, 32'h200, 2'b01));
      tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,   32'h0,   2'd1, 4'd2, 1, 2'b11, 32'h200, 32'h201, 2'b10));
      tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,   32'h0,   2'd1, 4'd1, 1, 2'b01, 32'h201, 32'h0,   2'b01));
      tbl.push_back(mk(0, 0, 0, 2'b00, 32'h0,   32'h0,   2'd1, 4'd0, 1, 2'b00, 32'h0,   32'h0,   2'b00));

      idle();
      rst = 1'b1;
      repeat (2) @(posedge gclk);
      #1;
      rst = 1'b0;
      #1;
      chk_all("reset", 4'd0, 1, 2'b00, 32'h0, 32'h0, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].fl, tbl[i].v, tbl[i].c, tbl[i].cm, tbl[i].a, tbl[i].b, tbl[i].dq);
         step();
         chk_all($sformatf("v%0d", i), tbl[i].e_occ, tbl[i].e_rdy, tbl[i].e_vld,
                 tbl[i].e_a, tbl[i].e_b, tbl[i].e_cm);
      end

      // Reset mid-stream discards both stored and incoming instructions.
      drive(0, 1, 1, 2'b00, 32'h60, 32'h61, 2'd0);
      step();
      chk_all("pre-rst", 4'd2, 1, 2'b11, 32'h60, 32'h61, 2'b00);
      drive(0, 1, 1, 2'b00, 32'h70, 32'h71, 2'd0);
      rst = 1'b1;
      @(posedge gclk);
      #1;
      rst = 1'b0;
      idle();
      #1;
      chk_all("mid-rst", 4'd0, 1, 2'b00, 32'h0, 32'h0, 2'b00);
      drive(0, 1, 0, 2'b01, 32'h80, 32'h0, 2'd0);
      step();
      chk_all("post-rst", 4'd1, 1, 2'b01, 32'h80, 32'h0, 2'b01);
      drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 2'd1);
      step();
      chk_all("post-rst drain", 4'd0, 1, 2'b00, 32'h0, 32'h0, 2'b00);

`ifdef WARP_IBUF_BYPASS_EN
      // Empty buffer: bundle visible the same cycle, decode takes one, one is kept.
      drive(0, 1, 1, 2'b10, 32'h300, 32'h301, 2'd1);
      #1;
      chk("byp same valid", 64'(bus.o_valid), 64'(2'b11));
      chk("byp same inst0", 64'(bus.o_inst0), 64'(32'h300));
      chk("byp same inst1", 64'(bus.o_inst1), 64'(32'h301));
      chk("byp same comp",  64'(bus.o_compressed), 64'(2'b10));
      step();
      chk_all("byp next", 4'd1, 1, 2'b01, 32'h301, 32'h0, 2'b01);
      drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 2'd1);
      step();
      chk_all("byp drain", 4'd0, 1, 2'b00, 32'h0, 32'h0, 2'b00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/warp_ibuf.md
Name: warp_ibuf

Overview:
- Instruction buffer on the receiving end of the fetch output handshake (valid/ready, inst0/inst1, compressed, count).
- Decouples fetch from decode. Accepts 1 or 2 instructions per cycle from fetch and queues them in order.
- Presents the oldest two to decode first-word-fall-through. Decode retires 0, 1 or 2 per cycle.
- Flushed on branch redirect.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- INST_W, 32, instruction width per entry (the compressed flag is stored alongside).

Ports:
- i_clk  input  1  clock; one clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  branch redirect; discard all queued and incoming instructions.
- i_input_valid  input  1  fetch bundle valid.
- o_input_ready  output  1  buffer can accept a full 2-instruction bundle.
- i_inst0  input  INST_W  older fetched instruction.
- i_inst1  input  INST_W  younger fetched instruction.
- i_compressed  input  2  bit k set: slot k was compressed.
- i_count  input  1  0 = only inst0 valid; 1 = inst0 and inst1 valid.
- o_inst0  output  INST_W  oldest queued instruction.
- o_inst1  output  INST_W  second-oldest queued instruction.
- o_compressed  output  2  compressed flags for o_inst0/o_inst1.
- o_valid  output  2  bit0: o_inst0 valid; bit1: o_inst1 valid.
- i_deq_count  input  2  instructions decode consumes this cycle (0..2).
- o_occupancy  output  clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage: circular array of DEPTH entries of {compressed, inst}.
- State: head and tail pointers, clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter clog2(DEPTH)+1 bits.
- Reset (i_rst high at the clock edge): head = tail = occupancy = 0. Outputs after reset: o_valid = 00, o_input_ready = 1, o_occupancy = 0. Stored data is don't-care but o_inst* are held 0 when not valid.
- o_input_ready = (DEPTH - occupancy) >= 2. Computed from registered occupancy only, with no combinational path from i_deq_count. A buffer holding DEPTH-1 entries therefore refuses even a 1-instruction bundle.
- Enqueue when i_input_valid & o_input_ready:
  - write inst0 at tail; if i_count, write inst1 at tail+1;
  - tail += 1 + i_count.
- Outputs, from registered state:
  - o_inst0/o_compressed[0] = entry[head]; o_inst1/o_compressed[1] = entry[head+1] (wrapping).
  - o_valid[0] = occupancy >= 1; o_valid[1] = occupancy >= 2.
- Dequeue: head += i_deq_count. Legal only when i_deq_count <= popcount(o_valid); i_deq_count = 3 is illegal. Both are assertion failures in simulation; RTL behaviour in those cases is undefined.
- Occupancy update: occupancy_next = occupancy + enq_n - deq_n in the same cycle. Simultaneous enqueue and dequeue is fully supported, including at occupancy 0 (dequeue 0 only) and at DEPTH-2.
- Latency, default build: an instruction accepted in cycle N is visible on o_inst* in cycle N+1.
- Flush (i_flush high): same effect as reset on head, tail and occupancy. The enqueue and dequeue in that cycle are ignored. Flush has priority over all other updates.
- Reset during operation behaves identically to flush; nothing is retained.
- Ordering: instructions leave in exactly the order received. inst0 is older than inst1 within a bundle.

Optional Feature:
- Macro: WARP_IBUF_BYPASS_EN.
- Defined, when occupancy == 0, i_input_valid = 1 and i_flush = 0:
  - i_inst*/i_compressed drive o_inst*/o_compressed combinationally;
  - o_valid = {i_count, 1}.
  - Decode may consume them in the same cycle. Only the unconsumed remainder (1 + i_count - i_deq_count entries) is written at tail, and head/tail advance accordingly.
  - This adds a combinational path from the fetch inputs to the outputs.
- Undefined: no bypass. Minimum latency is 1 cycle, and outputs depend only on registered state.

Decomposition:
- Package warp_pkg holds:
  - INST_W;
  - entry width (INST_W+1);
  - deq-count encodings (DEQ_NONE = 0, DEQ_ONE = 1, DEQ_TWO = 2).
- Sub-module warp_ibuf_ram is natural: a DEPTH-entry register array with 2 write ports (addr, data, en) and 2 asynchronous read ports, no reset. warp_ibuf holds the pointers, counter, handshake and bypass logic.

Test Plan:
- Reset, then 4 cycles of bundles (count = 1, inst = 0x0000_0013 + n) with i_deq_count = 0 → occupancy 2,4,6,8; o_input_ready falls at occupancy 7 or more (DEPTH = 8); o_inst0 = first instruction.
- Occupancy 7, i_input_valid = 1, count = 0 → not accepted (ready = 0); dequeue 1 → occupancy 6, ready = 1 next cycle.
- Steady state: enqueue 2 and dequeue 2 every cycle for 20 cycles → occupancy constant, order preserved, head/tail wrap modulo 8 correctly.
- Occupancy 5, i_flush = 1 together with valid input and i_deq_count = 2 → next cycle occupancy 0, o_valid = 00, ready = 1.
- Mixed bundle: count = 0 with compressed = 01, then count = 1 with compressed = 10 → outputs show compressed flags 01 then 00/01 correctly per slot; odd head alignment handled.
- With WARP_IBUF_BYPASS_EN and empty buffer: valid bundle, count = 1, i_deq_count = 1 → same-cycle o_valid = 11; next cycle occupancy 1 and o_inst0 = old inst1.
